// File: rtl/ep_trn_arb.sv
// Round-robin arbiter for the shared TRN tx interface with grant timeout and TLP tag allocation.
// States: IDLE no owner | OFFER grant offered, waiting for drv_ep | OWNED owner driving | GAP one dead cycle
module ep_trn_arb #(
    parameter int GRANT_TO = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] drv_ep,
    input  logic [2:0] tag_inc,
    output logic [2:0] my_trn,
    output logic [4:0] tag_trn,
    output logic       busy,
    output logic       proto_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        OWNED = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(GRANT_TO - 1);

    state_t     state, state_nxt;
    logic [1:0] owner, owner_nxt;
    logic [1:0] last, last_nxt;
    logic [7:0] wcnt, wcnt_nxt;
    logic [2:0] my_trn_nxt;
    logic [2:0] my_trn_prev;

    logic [1:0] o0, o1, o2;
    logic [1:0] pick;
    logic       own_drv, own_req;
    logic [2:0] last_beat;
    logic       tag_hit, tag_rogue, drv_rogue;

    // Search order starts just after the previous owner; last=2 wraps to 0.
    always_comb begin
        o0 = 2'd0;
        o1 = 2'd1;
        o2 = 2'd2;
        case (last)
            2'd0: begin o0 = 2'd1; o1 = 2'd2; o2 = 2'd0; end
            2'd1: begin o0 = 2'd2; o1 = 2'd0; o2 = 2'd1; end
            default: begin o0 = 2'd0; o1 = 2'd1; o2 = 2'd2; end
        endcase
        if (req[o0])
            pick = o0;
        else if (req[o1])
            pick = o1;
        else
            pick = o2;
    end

    assign own_drv = drv_ep[owner];
    assign own_req = req[owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 2'd0;
            last        <= 2'd2;
            wcnt        <= 8'd0;
            my_trn      <= 3'b000;
            my_trn_prev <= 3'b000;
        end else begin
            state       <= state_nxt;
            owner       <= owner_nxt;
            last        <= last_nxt;
            wcnt        <= wcnt_nxt;
            my_trn      <= my_trn_nxt;
            my_trn_prev <= my_trn;
        end
    end

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        last_nxt   = last;
        wcnt_nxt   = wcnt;
        my_trn_nxt = my_trn;
        case (state)
            IDLE: begin
                my_trn_nxt = 3'b000;
                if (|req) begin
                    state_nxt  = OFFER;
                    owner_nxt  = pick;
                    my_trn_nxt = 3'b001 << pick;
                    wcnt_nxt   = 8'd0;
                end
            end
            OFFER: begin
                wcnt_nxt = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
                // Driving wins over a simultaneous request drop or timeout.
                if (own_drv) begin
                    state_nxt = OWNED;
                end else if (!own_req || (wcnt == TO_LAST)) begin
                    state_nxt  = GAP;
                    my_trn_nxt = 3'b000;
                    last_nxt   = owner;
                end
            end
            OWNED: begin
                if (!own_drv) begin
                    state_nxt  = GAP;
                    my_trn_nxt = 3'b000;
                    last_nxt   = owner;
                end
            end
            default: begin
                state_nxt  = IDLE;
                my_trn_nxt = 3'b000;
            end
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    // The former owner may still be finishing its final beat one cycle after losing the grant.
    assign last_beat = my_trn_prev & ~my_trn;
    assign tag_hit   = |(tag_inc & my_trn);
    assign tag_rogue = |(tag_inc & ~my_trn);
    assign drv_rogue = |(drv_ep & ~my_trn & ~last_beat);

    always_ff @(posedge clk) begin
        if (rst) begin
            tag_trn   <= 5'd0;
            proto_err <= 1'b0;
        end else begin
            if (tag_hit)
                tag_trn <= tag_trn + 5'd1;
            if (tag_rogue || drv_rogue)
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ep_trn_arb.sv
// Directed bench for ep_trn_arb: grant flow, rotation, timeout, tag wrap, protocol errors, reset.
module tb_ep_trn_arb;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [2:0] drv_ep;
    logic [2:0] tag_inc;
    logic [2:0] my_trn;
    logic [4:0] tag_trn;
    logic       busy;
    logic       proto_err;

    int n_cmp = 0;
    int n_err = 0;

    ep_trn_arb #(.GRANT_TO(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .drv_ep    (drv_ep),
        .tag_inc   (tag_inc),
        .my_trn    (my_trn),
        .tag_trn   (tag_trn),
        .busy      (busy),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called right after the edge that should raise the grant; returns with the FSM back in IDLE.
    task automatic serve(input logic [2:0] g, input logic [4:0] exp_tag);
        chk("rot_grant", 32'(my_trn), 32'(g));
        drv_ep  = g;
        tag_inc = g;
        tick();
        chk("rot_tag", 32'(tag_trn), 32'(exp_tag));
        chk("rot_owned", 32'(my_trn), 32'(g));
        tag_inc = 3'b000;
        tick();
        tick();
        drv_ep = 3'b000;
        tick();
        chk("rot_gap", 32'(my_trn), 32'd0);
        chk("rot_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("rot_idle", 32'(my_trn), 32'd0);
        chk("rot_idle_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        // reset with hostile inputs, which must be ignored
        rst = 1'b1; req = 3'b111; drv_ep = 3'b111; tag_inc = 3'b111;
        tick();
        tick();
        chk("rst_my_trn", 32'(my_trn), 32'd0);
        chk("rst_tag", 32'(tag_trn), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_perr", 32'(proto_err), 32'd0);
        rst = 1'b0; req = 3'b000; drv_ep = 3'b000; tag_inc = 3'b000;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);

        // single requester 1, drives two cycles after the grant for five cycles
        req = 3'b010;
        tick();
        chk("t1_grant", 32'(my_trn), 32'b010);
        chk("t1_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_offer", 32'(my_trn), 32'b010);
        tick();
        drv_ep = 3'b010;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t1_owned", 32'(my_trn), 32'b010);
            chk("t1_owned_busy", 32'(busy), 32'd1);
        end
        drv_ep = 3'b000;
        req = 3'b000;
        tick();
        chk("t1_gap", 32'(my_trn), 32'd0);
        chk("t1_gap_busy", 32'(busy), 32'd1);
        tick();
        chk("t1_idle_busy", 32'(busy), 32'd0);
        chk("t1_perr", 32'(proto_err), 32'd0);

        // all three requesting: rotation 0,1,2,0 with one tag each
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 3'b111;
        tick();
        serve(3'b001, 5'd1);
        tick();
        serve(3'b010, 5'd2);
        tick();
        serve(3'b100, 5'd3);
        tick();
        chk("rot_fourth", 32'(my_trn), 32'b001);
        req = 3'b000;
        tick();
        chk("drop_gap", 32'(my_trn), 32'd0);
        tick();
        chk("drop_idle", 32'(busy), 32'd0);
        chk("rot_tag_final", 32'(tag_trn), 32'd3);
        chk("rot_perr", 32'(proto_err), 32'd0);

        // requester 2 never drives: grant held exactly 8 cycles
        req = 3'b101;
        tick();
        chk("to_grant", 32'(my_trn), 32'b100);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk("to_hold", 32'(my_trn), 32'b100);
        end
        tick();
        chk("to_gap", 32'(my_trn), 32'd0);
        chk("to_gap_busy", 32'(busy), 32'd1);
        drv_ep = 3'b100;
        tick();
        drv_ep = 3'b000;
        chk("to_idle", 32'(my_trn), 32'd0);
        chk("last_beat_perr", 32'(proto_err), 32'd0);
        tick();
        chk("to_next_grant", 32'(my_trn), 32'b001);
        req = 3'b000;
        tick();
        tick();
        chk("pre_rogue_perr", 32'(proto_err), 32'd0);
        drv_ep = 3'b010;
        tick();
        drv_ep = 3'b000;
        chk("rogue_drv_perr", 32'(proto_err), 32'd1);

        // tag wrap and non-owner tag_inc
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst2_perr", 32'(proto_err), 32'd0);
        req = 3'b001;
        tick();
        chk("w_grant", 32'(my_trn), 32'b001);
        drv_ep = 3'b001;
        tick();
        for (int i = 0; i < 31; i++) begin
            tag_inc = 3'b001;
            tick();
            tag_inc = 3'b000;
            tick();
        end
        chk("w_tag31", 32'(tag_trn), 32'd31);
        chk("w_perr0", 32'(proto_err), 32'd0);
        tag_inc = 3'b011;
        tick();
        tag_inc = 3'b000;
        chk("w_wrap", 32'(tag_trn), 32'd0);
        chk("w_perr1", 32'(proto_err), 32'd1);
        tick();
        chk("w_sticky", 32'(proto_err), 32'd1);
        chk("w_no_extra", 32'(tag_trn), 32'd0);

        // reset mid-OWNED
        tag_inc = 3'b001;
        tick();
        tag_inc = 3'b000;
        chk("m_tag1", 32'(tag_trn), 32'd1);
        chk("m_owned", 32'(my_trn), 32'b001);
        rst = 1'b1;
        req = 3'b111;
        tick();
        chk("m_rst_trn", 32'(my_trn), 32'd0);
        chk("m_rst_tag", 32'(tag_trn), 32'd0);
        chk("m_rst_perr", 32'(proto_err), 32'd0);
        chk("m_rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        drv_ep = 3'b000;
        tick();
        chk("m_post_grant", 32'(my_trn), 32'b001);
        chk("m_post_perr", 32'(proto_err), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
